// File: rtl/pixel_collector.sv
// pixel_collector: assembles the serial result bit stream MSB-first into
// PIXEL_BITS-wide pixels and buffers them in a first-word-fall-through FIFO
// for the scan-out pipeline.
// Optional feature macro: PIXEL_COLLECTOR_STATUS_EN (sticky overflow/underflow).
module pixel_collector #(
  parameter int unsigned PIXEL_BITS = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_bit,
  input  logic                              output_bit,
  input  logic                              flush,
  input  logic                              pop,
  output logic [PIXEL_BITS-1:0]             pixel,
  output logic                              pixel_valid,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]       fill_level,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int unsigned CW = $clog2(PIXEL_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [PIXEL_BITS-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic [PIXEL_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;

  logic [PIXEL_BITS-1:0] word_c;
  logic                  complete_c;
  logic                  do_pop_c;
  logic                  do_push_c;
  logic [LW-1:0]         level_nxt_c;

  // Head of FIFO falls through combinationally; RAM is cleared so it reads 0 when empty after reset/flush
  assign pixel = mem[rd_ptr];

  // Pixel completion and FIFO push/pop decisions
  always_comb begin
    word_c      = {shift_q[PIXEL_BITS-2:0], output_bit};
    complete_c  = valid_bit && (cnt_q == CW'(PIXEL_BITS - 1));
    do_pop_c    = pop && (fill_level != '0);
    do_push_c   = complete_c && (!fifo_full || do_pop_c);
    level_nxt_c = fill_level + LW'(do_push_c) - LW'(do_pop_c);
  end

  // Serial-to-parallel assembler; idle cycles leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (valid_bit) begin
      shift_q <= word_c;
      cnt_q   <= complete_c ? '0 : cnt_q + CW'(1);
    end
  end

  // Pixel storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (do_push_c) begin
      mem[wr_ptr] <= word_c;
    end
  end

  // Pointers and registered occupancy/status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fill_level  <= '0;
      pixel_valid <= 1'b0;
      fifo_full   <= 1'b0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fill_level  <= '0;
      pixel_valid <= 1'b0;
      fifo_full   <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      fill_level  <= level_nxt_c;
      pixel_valid <= (level_nxt_c != '0);
      fifo_full   <= (level_nxt_c == LW'(FIFO_DEPTH));
    end
  end

`ifdef PIXEL_COLLECTOR_STATUS_EN
  // Sticky error flags: dropped pixel, pop on empty FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (complete_c && fifo_full && !do_pop_c) overflow <= 1'b1;
      if (pop && (fill_level == '0))            underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_collector.sv
// Scoreboard bench for pixel_collector: stimulus queues expected pixels,
// a negedge monitor checks every popped head against the queue.
module tb_pixel_collector;

  localparam int unsigned PB = 4;
  localparam int unsigned DEPTH = 8;
`ifdef PIXEL_COLLECTOR_STATUS_EN
  localparam int STATUS = 1;
`else
  localparam int STATUS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_bit = 1'b0;
  logic          output_bit = 1'b0;
  logic          flush = 1'b0;
  logic          pop = 1'b0;
  logic [PB-1:0] pixel;
  logic          pixel_valid;
  logic          fifo_full;
  logic [3:0]    fill_level;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  pixel_collector #(.PIXEL_BITS(PB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_bit(valid_bit), .output_bit(output_bit),
    .flush(flush), .pop(pop), .pixel(pixel), .pixel_valid(pixel_valid),
    .fifo_full(fifo_full), .fill_level(fill_level), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; inputs return to idle afterwards
  task automatic drive(input logic vb, input logic ob, input logic pp, input logic fl);
    valid_bit = vb; output_bit = ob; pop = pp; flush = fl;
    @(posedge clk); #1;
    valid_bit = 1'b0; output_bit = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic send_pixel(input logic [PB-1:0] p, input logic pop_last);
    for (int i = PB - 1; i >= 0; i--) drive(1'b1, p[i], pop_last && (i == 0), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: each accepted pop must present the oldest expected pixel
  always @(negedge clk) begin
    if (!rst && pop && pixel_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pixel %0d expected no pixel at %0t", pixel, $time);
      end else begin
        check("pop_pixel", int'(pixel), exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_fill_level", fill_level, 0);
    check("rst_pixel", pixel, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b0;
    idle(1);

    // Bits 1,0,1,1 -> 0xB one cycle after the last bit
    send_pixel(4'hB, 1'b0);
    exp_q.push_back(4'hB);
    check("b_pixel_valid", pixel_valid, 1);
    check("b_pixel", pixel, 4'hB);
    check("b_fill_level", fill_level, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("b_empty_after_pop", pixel_valid, 0);

    // Bits 1,1 / gap / 0,1 -> 0xD
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("gap_no_push", fill_level, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'hD);
    check("d_pixel", pixel, 4'hD);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Fill to full, drop ninth pixel
    for (int k = 0; k < 8; k++) begin
      send_pixel(PB'(k), 1'b0);
      exp_q.push_back(k);
    end
    check("full_flag", fifo_full, 1);
    check("full_level", fill_level, 8);
    check("full_no_overflow", overflow, 0);
    send_pixel(4'hF, 1'b0);
    check("drop_level", fill_level, 8);
    check("drop_overflow", overflow, STATUS);
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_valid", pixel_valid, 0);
    check("drain_level", fill_level, 0);
    check("drain_underflow", underflow, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_overflow", overflow, 0);

    // Full FIFO, completion coincident with pop
    for (int k = 0; k < 8; k++) begin
      send_pixel(PB'(k), 1'b0);
      exp_q.push_back(k);
    end
    send_pixel(4'hF, 1'b1);
    exp_q.push_back(4'hF);
    check("pp_level", fill_level, 8);
    check("pp_full", fifo_full, 1);
    check("pp_overflow", overflow, 0);
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("pp_last_head", pixel, 4'hF);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("pp_drained", pixel_valid, 0);

    // Pop on empty, then flush
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("uf_flag", underflow, STATUS);
    check("uf_level", fill_level, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("uf_flush_underflow", underflow, 0);
    check("uf_flush_overflow", overflow, 0);

    // Asynchronous reset mid-pixel with a stored pixel present
    send_pixel(4'h9, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", pixel_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pixel_valid", pixel_valid, 0);
    check("arst_pixel", pixel, 0);
    check("arst_fill_level", fill_level, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_pixel(4'h6, 1'b0);
    exp_q.push_back(4'h6);
    check("post_rst_pixel", pixel, 4'h6);
    check("post_rst_level", fill_level, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
